image_pixel_streamer: RTL and testbench

- Downstream consumer of the dual-port `image_rom`. Drives one ROM read port (address plus read enable) and walks a frame of 24-bit RGB pixels in raster order.
- Absorbs the ROM's fixed read latency and presents the pixels as a valid/ready stream to the next processing stage.
- Each beat carries the raw RGB word, an 8-bit luma value and an end-of-frame marker.
- Sits between `image_rom` port A and the filter/processing pipeline; a start/done pair lets the control FSM trigger one frame at a time.

---
 rtl/image_pkg.sv | 35 +++
 rtl/pixel_fifo.sv | 68 ++++++
 rtl/image_pixel_streamer.sv | 149 ++++++++++++++
 tb/tb_image_pixel_streamer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared constants, pixel types and the luma helper for the image streaming path.
package image_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 24;
  localparam int IMG_W  = 320;
  localparam int IMG_H  = 240;

  localparam int LUMA_R = 77;
  localparam int LUMA_G = 150;
  localparam int LUMA_B = 29;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } stream_state_t;

  // Coefficients sum to 256, so the 16-bit accumulator cannot overflow.
  function automatic logic [7:0] rgb_to_gray(input rgb_t px);
    logic [15:0] w_acc;
    w_acc = 16'(LUMA_R) * {8'd0, px.r}
          + 16'(LUMA_G) * {8'd0, px.g}
          + 16'(LUMA_B) * {8'd0, px.b};
    return w_acc[15:8];
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO with a combinational head, used to absorb ROM read latency
// and downstream backpressure.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 25,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);
  import image_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && !o_full;

  // Head is read combinationally so a beat is presented the cycle after it is written.
  assign o_rdata = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/image_pixel_streamer.sv
// Walks one frame of the image ROM in raster order and presents the pixels as a
// valid/ready stream with luma and end-of-frame marker.
module image_pixel_streamer #(
  parameter int ADDR_W       = image_pkg::ADDR_W,
  parameter int DATA_W       = image_pkg::DATA_W,
  parameter int NUM_PIXELS   = 76800,
  parameter int BASE_ADDR    = 0,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rom_rden,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_q,
  output logic              o_pix_valid,
  input  logic              i_pix_ready,
  output logic [DATA_W-1:0] o_pix_data,
  output logic [7:0]        o_pix_gray,
  output logic              o_pix_last
);
  import image_pkg::*;

  localparam int CNT_W  = $clog2(NUM_PIXELS + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W  = $clog2(READ_LATENCY + 1);

  stream_state_t            r_state;
  stream_state_t            w_state_next;
  logic [ADDR_W-1:0]        r_addr;
  logic [CNT_W-1:0]         r_issue_cnt;
  logic [READ_LATENCY-1:0]  r_pipe_vld;
  logic [READ_LATENCY-1:0]  r_pipe_last;
  logic [INF_W-1:0]         w_inflight;
  logic                     w_issue;
  logic                     w_issue_last;
  logic                     w_load;
  logic                     w_credit;
  logic                     w_push;
  logic                     w_pop;
  logic [DATA_W:0]          w_head;
  logic [FCNT_W-1:0]        w_fifo_count;
  logic                     w_fifo_empty;
  logic                     w_fifo_full;
  rgb_t                     w_head_rgb;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_inflight = w_inflight + INF_W'(r_pipe_vld[i]);
    end
  end

  // Reads already launched plus buffered beats must fit in the FIFO, so a push never overflows.
  assign w_credit     = (32'(w_inflight) + 32'(w_fifo_count)) < 32'(FIFO_DEPTH);
  assign w_issue_last = (r_issue_cnt == CNT_W'(NUM_PIXELS - 1));

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_next = ISSUE;
          w_load       = 1'b1;
        end
      end
      ISSUE: begin
        if (w_credit) begin
          w_issue = 1'b1;
          if (w_issue_last) begin
            w_state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Leaving on the pop of the final beat makes done follow acceptance by one cycle.
        if ((w_inflight == '0) &&
            (w_fifo_empty || ((w_fifo_count == FCNT_W'(1)) && w_pop))) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= ADDR_W'(BASE_ADDR);
      r_issue_cnt <= '0;
      r_pipe_vld  <= '0;
      r_pipe_last <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_addr      <= ADDR_W'(BASE_ADDR);
        r_issue_cnt <= '0;
      end else if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
        if (!w_issue_last) begin
          r_addr <= r_addr + ADDR_W'(1);
        end
      end
      r_pipe_vld[0]  <= w_issue;
      r_pipe_last[0] <= w_issue && w_issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_last[i] <= r_pipe_last[i-1];
      end
    end
  end

  assign w_push = r_pipe_vld[READ_LATENCY-1];
  assign w_pop  = o_pix_valid && i_pix_ready;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({r_pipe_last[READ_LATENCY-1], i_rom_q}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_fifo_full));

  assign o_busy      = (r_state == ISSUE) || (r_state == DRAIN);
  assign o_done      = (r_state == DONE);
  assign o_rom_rden  = w_issue;
  assign o_rom_addr  = r_addr;
  assign o_pix_valid = !w_fifo_empty;
  assign o_pix_data  = w_fifo_empty ? '0 : w_head[DATA_W-1:0];
  assign o_pix_last  = !w_fifo_empty && w_head[DATA_W];
  assign w_head_rgb  = rgb_t'(o_pix_data[23:0]);
  assign o_pix_gray  = rgb_to_gray(w_head_rgb);

endmodule

// File: tb/tb_image_pixel_streamer.sv
// Two streamer instances (latency 1 / base 0 / 8 pixels and latency 2 / base 100 / 5 pixels)
// checked every cycle against a frame-level model of the expected stream.
module tb_image_pixel_streamer;

  localparam int NI    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_v [NI];
  logic        start_v [NI];
  logic        ready_v [NI];
  logic        busy_v  [NI];
  logic        done_v  [NI];
  logic        rden_v  [NI];
  logic        valid_v [NI];
  logic        last_v  [NI];
  logic [16:0] addr_v  [NI];
  logic [23:0] data_v  [NI];
  logic [7:0]  gray_v  [NI];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int cfg_num(input int g);
    return (g == 0) ? 8 : 5;
  endfunction

  function automatic int cfg_base(input int g);
    return (g == 0) ? 0 : 100;
  endfunction

  function automatic logic [23:0] rom_word(input int g, input int a);
    if (g == 0) return 24'(a * 3);
    case (a)
      100:     return 24'hFFFFFF;
      101:     return 24'h000000;
      102:     return 24'hFF0000;
      103:     return 24'h00FF00;
      104:     return 24'h0000FF;
      default: return 24'h5A5A5A;
    endcase
  endfunction

  function automatic logic [7:0] luma(input logic [23:0] w);
    int y;
    y = (77 * int'(w[23:16]) + 150 * int'(w[15:8]) + 29 * int'(w[7:0])) / 256;
    return 8'(y);
  endfunction

  function automatic logic [7:0] pin_gray(input int k);
    case (k)
      0:       return 8'd255;
      1:       return 8'd0;
      2:       return 8'd76;
      3:       return 8'd149;
      default: return 8'd28;
    endcase
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int NUM  = (gi == 0) ? 8 : 5;
    localparam int BASE = (gi == 0) ? 0 : 100;
    localparam int LAT  = (gi == 0) ? 1 : 2;

    logic [23:0] rom_q;
    logic [23:0] rom_s1;

    image_pixel_streamer #(
      .ADDR_W       (17),
      .DATA_W       (24),
      .NUM_PIXELS   (NUM),
      .BASE_ADDR    (BASE),
      .READ_LATENCY (LAT),
      .FIFO_DEPTH   (DEPTH)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n_v[gi]),
      .i_start     (start_v[gi]),
      .o_busy      (busy_v[gi]),
      .o_done      (done_v[gi]),
      .o_rom_rden  (rden_v[gi]),
      .o_rom_addr  (addr_v[gi]),
      .i_rom_q     (rom_q),
      .o_pix_valid (valid_v[gi]),
      .i_pix_ready (ready_v[gi]),
      .o_pix_data  (data_v[gi]),
      .o_pix_gray  (gray_v[gi]),
      .o_pix_last  (last_v[gi])
    );

    // Behavioural ROM port with LAT clocks from the read edge to valid data.
    always @(posedge clk) begin
      if (rden_v[gi]) rom_s1 <= rom_word(gi, int'(addr_v[gi]));
      if (LAT == 1) begin
        if (rden_v[gi]) rom_q <= rom_word(gi, int'(addr_v[gi]));
      end else begin
        rom_q <= rom_s1;
      end
    end
  end

  task automatic chk(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", name, g, $time, act, exp);
    end
  endtask

  // Frame model: phase 0 idle, 1 streaming (busy), 2 the done cycle.
  int          cyc = 0;
  int          phase     [NI];
  int          issued    [NI];
  int          accepted  [NI];
  int          start_cyc [NI];
  bit          seen_valid[NI];
  bit          stalled   [NI];
  bit          prev_stall[NI];
  logic [23:0] prev_data [NI];
  logic [23:0] cap_data  [NI][8];
  logic [7:0]  cap_gray  [NI][8];
  logic        cap_last  [NI][8];

  always @(negedge clk) begin
    cyc++;
    for (int g = 0; g < NI; g++) begin
      int num;
      int base;
      int next_phase;
      num  = cfg_num(g);
      base = cfg_base(g);
      if (!rst_n_v[g]) begin
        chk("reset_outputs", g,
            {busy_v[g], done_v[g], rden_v[g], valid_v[g], last_v[g], gray_v[g], data_v[g], addr_v[g]},
            {5'b0, 8'd0, 24'd0, 17'(base)});
        phase[g]      = 0;
        issued[g]     = 0;
        accepted[g]   = 0;
        prev_stall[g] = 1'b0;
      end else begin
        next_phase = phase[g];
        chk("busy", g, 64'(busy_v[g]), 64'(phase[g] == 1));
        chk("done", g, 64'(done_v[g]), 64'(phase[g] == 2));
        if (phase[g] == 1 && issued[g] < num)
          chk("rom_rden", g, 64'(rden_v[g]), 64'((issued[g] - accepted[g]) < DEPTH));
        else
          chk("rom_rden_idle", g, 64'(rden_v[g]), 64'(0));
        if (rden_v[g]) begin
          chk("rom_addr", g, 64'(addr_v[g]), 64'(base + issued[g]));
          issued[g]++;
        end
        if (valid_v[g]) begin
          if (phase[g] != 1) begin
            chk("valid_outside_frame", g, 64'(valid_v[g]), 64'(0));
          end else begin
            if (!seen_valid[g]) begin
              chk("first_valid_latency", g, 64'(cyc - start_cyc[g]), (g == 0) ? 64'd3 : 64'd4);
              seen_valid[g] = 1'b1;
            end
            chk("pix_data", g, 64'(data_v[g]), 64'(rom_word(g, base + accepted[g])));
            chk("pix_gray", g, 64'(gray_v[g]), 64'(luma(rom_word(g, base + accepted[g]))));
            chk("pix_last", g, 64'(last_v[g]), 64'(accepted[g] == num - 1));
            if (prev_stall[g]) chk("stall_hold", g, 64'(data_v[g]), 64'(prev_data[g]));
          end
        end else if (phase[g] == 1 && seen_valid[g] && !stalled[g] && accepted[g] < num) begin
          chk("full_rate", g, 64'(valid_v[g]), 64'(1));
        end
        prev_stall[g] = valid_v[g] && !ready_v[g];
        prev_data[g]  = data_v[g];
        if (phase[g] == 1 && !ready_v[g]) stalled[g] = 1'b1;
        if (valid_v[g] && ready_v[g] && phase[g] == 1) begin
          if (accepted[g] < 8) begin
            cap_data[g][accepted[g]] = data_v[g];
            cap_gray[g][accepted[g]] = gray_v[g];
            cap_last[g][accepted[g]] = last_v[g];
          end
          accepted[g]++;
          if (accepted[g] == num) begin
            next_phase = 2;
            if (g == 0) begin
              chk("pin_data_2", g, 64'(cap_data[0][2]), 64'd6);
              chk("pin_data_7", g, 64'(cap_data[0][7]), 64'd21);
              chk("pin_last_7", g, 64'(cap_last[0][7]), 64'd1);
              chk("pin_last_6", g, 64'(cap_last[0][6]), 64'd0);
            end else begin
              for (int k = 0; k < 5; k++) chk("pin_gray", g, 64'(cap_gray[1][k]), 64'(pin_gray(k)));
              chk("pin_data_0", g, 64'(cap_data[1][0]), 64'hFFFFFF);
            end
          end
        end
        if (phase[g] == 1 && (cyc - start_cyc[g]) > 400) begin
          chk("frame_timeout", g, 64'(cyc - start_cyc[g]), 64'd400);
          next_phase = 0;
        end
        if (phase[g] == 0 && start_v[g]) begin
          next_phase    = 1;
          start_cyc[g]  = cyc;
          issued[g]     = 0;
          accepted[g]   = 0;
          seen_valid[g] = 1'b0;
          stalled[g]    = 1'b0;
        end else if (phase[g] == 2) begin
          next_phase = 0;
        end
        phase[g] = next_phase;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0,1.
  task automatic run_frame(input int g, input int mode, input bit restart_mid, input bit start_at_done);
    bit fin;
    fin = 1'b0;
    start_v[g] = 1'b1;
    tick();
    start_v[g] = 1'b0;
    for (int k = 0; k < 300 && !fin; k++) begin
      ready_v[g] = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      start_v[g] = restart_mid && (k == 3);
      if (done_v[g]) begin
        start_v[g] = start_at_done;
        fin = 1'b1;
      end
      tick();
    end
    start_v[g] = 1'b0;
    ready_v[g] = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    int nb;
    for (int g = 0; g < NI; g++) begin
      rst_n_v[g] = 1'b0;
      start_v[g] = 1'b0;
      ready_v[g] = 1'b1;
    end
    repeat (3) tick();
    for (int g = 0; g < NI; g++) rst_n_v[g] = 1'b1;
    repeat (2) tick();

    run_frame(0, 0, 1'b0, 1'b0);
    run_frame(0, 1, 1'b0, 1'b0);
    run_frame(1, 0, 1'b0, 1'b0);
    run_frame(1, 1, 1'b0, 1'b0);
    run_frame(0, 0, 1'b1, 1'b1);

    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    nb = 0;
    for (int k = 0; k < 100 && nb < 3; k++) begin
      @(negedge clk);
      if (valid_v[0] && ready_v[0]) nb++;
      tick();
    end
    rst_n_v[0] = 1'b0;
    repeat (2) tick();
    rst_n_v[0] = 1'b1;
    repeat (2) tick();
    run_frame(0, 0, 1'b0, 1'b0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
